// File: rtl/sc_ram_pkg.sv
// Shared types and constants for the byte-enable RAM.
package sc_ram_pkg;

  // Controller phases: zero-fill after reset, then normal traffic
  typedef enum logic {
    INIT,
    READY
  } state_t;

  // Read-during-write selections for same-address collisions
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/sc_ram_be_core.sv
// Storage array with a byte-masked write port and a registered read port.
// Contents are never reset; all control lives in the wrapper.
module sc_ram_be_core #(
  parameter int DWIDTH = 64,
  parameter int AWIDTH = 10
) (
  input  logic                   i_clk,
  input  logic                   i_we,
  input  logic [DWIDTH/8-1:0]    i_be,
  input  logic [AWIDTH-1:0]      i_waddr,
  input  logic [DWIDTH-1:0]      i_wdata,
  input  logic                   i_re,
  input  logic [AWIDTH-1:0]      i_raddr,
  output logic [DWIDTH-1:0]      o_rdata
);

  localparam int BEW   = DWIDTH / 8;
  localparam int DEPTH = 2 ** AWIDTH;

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [DWIDTH-1:0] r_rdata;

  // Byte-masked write and registered read; a same-edge read sees the pre-write word
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int k = 0; k < BEW; k++) begin
        if (i_be[k]) begin
          r_mem[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
        end
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sc_ram_be.sv
// Dual-port RAM with byte enables, selectable read-during-write result,
// optional output register, read-valid strobe and post-reset zero fill.
module sc_ram_be
  import sc_ram_pkg::*;
#(
  parameter int DWIDTH          = 64,
  parameter int AWIDTH          = 10,
  parameter int REGISTER_OUTPUT = 0,
  parameter int RDW_MODE        = 0,
  parameter int INIT_ON_RESET   = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DWIDTH-1:0]      data_i,
  input  logic [AWIDTH-1:0]      wr_addr_i,
  input  logic [DWIDTH/8-1:0]    wr_be_i,
  input  logic                   wr_en_i,
  input  logic [AWIDTH-1:0]      rd_addr_i,
  input  logic                   rd_en_i,
  output logic [DWIDTH-1:0]      data_o,
  output logic                   data_val_o,
  output logic                   init_done_o
);

  localparam int BEW = DWIDTH / 8;

  state_t             r_state;
  state_t             w_nextState;
  logic [AWIDTH-1:0]  r_clrCnt;
  logic               r_initDone;
  logic               w_initDoneNext;
  logic               w_initWrite;

  logic               w_wrAcc;
  logic               w_rdAcc;
  logic               w_collide;

  logic               w_coreWe;
  logic [BEW-1:0]     w_coreBe;
  logic [AWIDTH-1:0]  w_coreAddr;
  logic [DWIDTH-1:0]  w_coreData;
  logic [DWIDTH-1:0]  w_coreRdata;

  logic [BEW-1:0]     r_bypMask;
  logic [DWIDTH-1:0]  r_bypData;
  logic [DWIDTH-1:0]  w_s1Data;
  logic               r_v1;

  // Controller state, clear counter and the registered ready flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= (INIT_ON_RESET != 0) ? INIT : READY;
      r_clrCnt   <= '0;
      r_initDone <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_initDone <= w_initDoneNext;
      if (w_initWrite) begin
        r_clrCnt <= r_clrCnt + 1'b1;
      end
    end
  end

  // Zero-fill walks every address once, then hands over to user traffic
  always_comb begin
    w_nextState    = r_state;
    w_initWrite    = 1'b0;
    w_initDoneNext = r_initDone;
    case (r_state)
      INIT: begin
        w_initWrite = 1'b1;
        if (r_clrCnt == {AWIDTH{1'b1}}) begin
          w_nextState    = READY;
          w_initDoneNext = 1'b1;
        end
      end
      READY: begin
        w_initDoneNext = 1'b1;
      end
      default: begin
        w_nextState = r_state;
      end
    endcase
  end

  assign init_done_o = r_initDone;

  // User requests are only honoured once the ready flag is visible
  assign w_wrAcc   = r_initDone & wr_en_i;
  assign w_rdAcc   = r_initDone & rd_en_i;
  assign w_collide = w_rdAcc & w_wrAcc & (rd_addr_i == wr_addr_i) & (RDW_MODE == RDW_NEW);

  assign w_coreWe   = w_initWrite | w_wrAcc;
  assign w_coreBe   = w_initWrite ? {BEW{1'b1}} : wr_be_i;
  assign w_coreAddr = w_initWrite ? r_clrCnt : wr_addr_i;
  assign w_coreData = w_initWrite ? '0 : data_i;

  sc_ram_be_core #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_core (
    .i_clk   (clk_i),
    .i_we    (w_coreWe),
    .i_be    (w_coreBe),
    .i_waddr (w_coreAddr),
    .i_wdata (w_coreData),
    .i_re    (w_rdAcc),
    .i_raddr (rd_addr_i),
    .o_rdata (w_coreRdata)
  );

  // Capture the colliding write's bytes so they can override the array's old word
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bypMask <= '0;
      r_bypData <= '0;
      r_v1      <= 1'b0;
    end else begin
      r_v1 <= w_rdAcc;
      if (w_rdAcc) begin
        r_bypMask <= w_collide ? wr_be_i : '0;
        r_bypData <= data_i;
      end
    end
  end

  // Merge bypassed bytes over the array read to form the first-stage result
  always_comb begin
    w_s1Data = w_coreRdata;
    for (int k = 0; k < BEW; k++) begin
      if (r_bypMask[k]) begin
        w_s1Data[8*k +: 8] = r_bypData[8*k +: 8];
      end
    end
  end

  generate
    if (REGISTER_OUTPUT != 0) begin : g_reg
      logic [DWIDTH-1:0] r_dout;
      logic              r_v2;

      // Second stage only loads when it carries a real read
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_dout <= '0;
          r_v2   <= 1'b0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) begin
            r_dout <= w_s1Data;
          end
        end
      end

      assign data_o     = r_dout;
      assign data_val_o = r_v2;
    end else begin : g_noreg
      logic r_seen;

      // Remember that a read has completed so the output shows zero until then
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_seen <= 1'b0;
        end else if (r_v1) begin
          r_seen <= 1'b1;
        end
      end

      assign data_o     = (r_v1 | r_seen) ? w_s1Data : '0;
      assign data_val_o = r_v1;
    end
  endgenerate

endmodule

// File: tb/tb_sc_ram_be.sv
// Self-checking bench: two RAM instances sharing stimulus, one with
// latency 1 and old-data collisions, one with latency 2 and new-data collisions.
module tb_sc_ram_be;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dataIn;
  logic [3:0]  wrAddr;
  logic [3:0]  wrBe;
  logic        wrEn;
  logic [3:0]  rdAddr;
  logic        rdEn;

  logic [31:0] dataA, dataB;
  logic        valA, valB, doneA, doneB;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] refMem [16];
  bit          modelDone;
  int          initCount;
  bit          expValA, expValB, pendValB;
  logic [31:0] expDatA, expDatB, pendDatB;

  typedef struct {
    bit          wrEn;
    logic [3:0]  wrAddr;
    logic [31:0] wrData;
    logic [3:0]  wrBe;
    bit          rdEn;
    logic [3:0]  rdAddr;
    logic [31:0] expA;
    logic [31:0] expB;
  } vec_t;

  always #5 clk = ~clk;

  sc_ram_be #(
    .DWIDTH(32), .AWIDTH(4), .REGISTER_OUTPUT(0), .RDW_MODE(0), .INIT_ON_RESET(1)
  ) dutA (
    .clk_i(clk), .rst_i(rst), .data_i(dataIn), .wr_addr_i(wrAddr), .wr_be_i(wrBe),
    .wr_en_i(wrEn), .rd_addr_i(rdAddr), .rd_en_i(rdEn),
    .data_o(dataA), .data_val_o(valA), .init_done_o(doneA)
  );

  sc_ram_be #(
    .DWIDTH(32), .AWIDTH(4), .REGISTER_OUTPUT(1), .RDW_MODE(1), .INIT_ON_RESET(1)
  ) dutB (
    .clk_i(clk), .rst_i(rst), .data_i(dataIn), .wr_addr_i(wrAddr), .wr_be_i(wrBe),
    .wr_en_i(wrEn), .rd_addr_i(rdAddr), .rd_en_i(rdEn),
    .data_o(dataB), .data_val_o(valB), .init_done_o(doneB)
  );

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldW, input logic [31:0] newW,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = oldW;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) r[8*k +: 8] = newW[8*k +: 8];
    end
    return r;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("initDoneA", {31'b0, doneA}, {31'b0, modelDone});
    checkVal("initDoneB", {31'b0, doneB}, {31'b0, modelDone});
    checkVal("validA", {31'b0, valA}, {31'b0, expValA});
    checkVal("validB", {31'b0, valB}, {31'b0, expValB});
    checkVal("dataA", dataA, expDatA);
    checkVal("dataB", dataB, expDatB);
  endtask

  task automatic modelReset();
    modelDone = 0;
    initCount = 0;
    expValA   = 0;
    expValB   = 0;
    pendValB  = 0;
    expDatA   = '0;
    expDatB   = '0;
    pendDatB  = '0;
  endtask

  // Drive one cycle of inputs, advance the model, clock, then compare
  task automatic applyStimulus(input bit we, input logic [3:0] wa, input logic [31:0] wd,
                               input logic [3:0] be, input bit re, input logic [3:0] ra);
    bit          rdAcc, wrAcc;
    logic [31:0] oldW, newW;
    wrEn = we; wrAddr = wa; dataIn = wd; wrBe = be; rdEn = re; rdAddr = ra;
    rdAcc = modelDone && re;
    wrAcc = modelDone && we;
    oldW  = refMem[ra];
    newW  = (wrAcc && wa == ra) ? mergeBytes(oldW, wd, be) : oldW;
    expValB = pendValB;
    if (pendValB) expDatB = pendDatB;
    pendValB = rdAcc;
    pendDatB = newW;
    expValA = rdAcc;
    if (rdAcc) expDatA = oldW;
    if (wrAcc) refMem[wa] = mergeBytes(refMem[wa], wd, be);
    if (!modelDone) begin
      refMem[initCount] = '0;
      initCount++;
      if (initCount == 16) modelDone = 1;
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(0, 4'h0, 32'h0, 4'h0, 0, 4'h0);
  endtask

  // Assert reset mid-cycle, check immediately and across an edge, then release
  task automatic doReset();
    rst = 1'b1;
    wrEn = 0; rdEn = 0;
    #1;
    modelReset();
    checkOutput();
    @(posedge clk);
    #1;
    checkOutput();
    #3;
    rst = 1'b0;
  endtask

  // Init with both request lines held high and random payloads
  task automatic gatedInit(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus(1, 4'($urandom_range(0, 15)), $urandom, 4'hF, 1, 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic readAllZero();
    for (int a = 0; a < 16; a++) begin
      applyStimulus(0, 4'h0, 32'h0, 4'h0, 1, 4'(a));
      checkVal("zeroReadA", dataA, 32'h0);
    end
    idle();
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t        tbl [8];
    logic [31:0] seqVals [4];

    rst = 1'b1; dataIn = '0; wrAddr = '0; wrBe = '0; wrEn = 0; rdAddr = '0; rdEn = 0;
    modelReset();
    for (int i = 0; i < 16; i++) refMem[i] = 'x;

    tbl[0] = '{1, 4'd3, 32'hAABBCCDD, 4'b1111, 0, 4'd0, 32'h0, 32'h0};
    tbl[1] = '{1, 4'd3, 32'h11223344, 4'b0101, 0, 4'd0, 32'h0, 32'h0};
    tbl[2] = '{0, 4'd0, 32'h0,        4'b0000, 1, 4'd3, 32'hAA22CC44, 32'hAA22CC44};
    tbl[3] = '{1, 4'd5, 32'h0,        4'b1111, 0, 4'd0, 32'h0, 32'h0};
    tbl[4] = '{1, 4'd5, 32'hFFFFFFFF, 4'b0011, 1, 4'd5, 32'h00000000, 32'h0000FFFF};
    tbl[5] = '{0, 4'd0, 32'h0,        4'b0000, 1, 4'd5, 32'h0000FFFF, 32'h0000FFFF};
    tbl[6] = '{1, 4'd7, 32'h12345678, 4'b0000, 1, 4'd7, 32'h0, 32'h0};
    tbl[7] = '{0, 4'd0, 32'h0,        4'b0000, 1, 4'd7, 32'h0, 32'h0};

    // Power-on reset and init length
    doReset();
    for (int i = 0; i < 16; i++) begin
      idle();
      checkVal("initLen", {31'b0, doneA}, (i == 15) ? 32'd1 : 32'd0);
    end
    readAllZero();

    // Directed vectors: byte enables, collisions, empty enable mask
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].wrEn, tbl[i].wrAddr, tbl[i].wrData, tbl[i].wrBe, tbl[i].rdEn, tbl[i].rdAddr);
      if (tbl[i].rdEn) begin
        checkVal($sformatf("tblValA%0d", i), {31'b0, valA}, 32'd1);
        checkVal($sformatf("tblDataA%0d", i), dataA, tbl[i].expA);
      end
      idle();
      if (tbl[i].rdEn) begin
        checkVal($sformatf("tblValB%0d", i), {31'b0, valB}, 32'd1);
        checkVal($sformatf("tblDataB%0d", i), dataB, tbl[i].expB);
      end
    end

    // Back-to-back reads through the two-stage instance
    for (int i = 0; i < 4; i++) begin
      seqVals[i] = 32'hC0DE0000 + 32'(i * 17);
      applyStimulus(1, 4'(i), seqVals[i], 4'hF, 0, 4'h0);
    end
    for (int j = 0; j < 6; j++) begin
      applyStimulus(0, 4'h0, 32'h0, 4'h0, j < 4, 4'(j));
      checkVal($sformatf("thruVal%0d", j), {31'b0, valB}, (j >= 1 && j <= 4) ? 32'd1 : 32'd0);
      if (j >= 1 && j <= 4) checkVal($sformatf("thruData%0d", j), dataB, seqVals[j-1]);
      if (j == 5) checkVal("thruHold", dataB, seqVals[3]);
    end

    // Randomized traffic with frequent address collisions
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom,
                    4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
                    4'($urandom_range(0, 15)));
    end

    // Reset with a read still in the second stage
    applyStimulus(0, 4'h0, 32'h0, 4'h0, 1, 4'd3);
    doReset();
    checkVal("midReadValB", {31'b0, valB}, 32'd0);
    gatedInit(5);

    // Reset during init restarts a full fill
    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 4'($urandom_range(0, 15)), $urandom, 4'hF, 1, 4'($urandom_range(0, 15)));
      checkVal("restartLen", {31'b0, doneB}, (i == 15) ? 32'd1 : 32'd0);
      checkVal("gateValA", {31'b0, valA}, 32'd0);
    end
    readAllZero();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
